// File: rtl/vga_capture.sv
// vga_capture: receive side of the VGA timing interface.
//
// Registers hsync/vsync/rgb once and recovers pixel coordinates from the
// registered syncs. It measures line and frame periods and reports a lock
// flag. On CPU request it captures one frame, down-sampled to one sample
// per 8x8 cell, into an internal buffer that the CPU can read.
//
// Ports:
//   clk          pixel clock, same clock as the video source
//   reset        synchronous, active-high
//   hsync/vsync  active-low syncs from the source
//   rgb          pixel colour, one bit per colour
//   mem_write    CPU write enable
//   address      CPU byte address
//   write_data   CPU write data
//   read_data    CPU read data, combinational from address:
//                  0..cells-1   buffer byte {5'b0, rgb}
//                  CTRL_ADDR    {4'b0, error, capture_done, busy, locked}
//                  others       8'h00
//   locked       line and frame timing match the expected values
//   capture_done a frame capture completed; cleared by arm, abort or reset
module vga_capture #(
  parameter int unsigned H_TOTAL   = 800,
  parameter int unsigned V_TOTAL   = 525,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned CELL_COLS = 80,
  parameter int unsigned CELL_ROWS = 60,
  parameter int unsigned CTRL_ADDR = 4800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  input  logic        mem_write,
  input  logic [15:0] address,
  input  logic [7:0]  write_data,
  output logic [7:0]  read_data,
  output logic        locked,
  output logic        capture_done
);

  localparam int unsigned NumCells = CELL_COLS * CELL_ROWS;
  localparam int unsigned IdxW     = $clog2(NumCells);
  localparam int unsigned LineW    = $clog2(2 * H_TOTAL + 1);
  localparam int unsigned FrameW   = $clog2(V_TOTAL + 1) + 1;

  localparam logic [9:0]        CoordMax = '1;
  localparam logic [LineW-1:0]  LineMax  = '1;
  localparam logic [FrameW-1:0] FrameMax = '1;

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  // ---------------------------------------------------------------------------
  // Input stage and edge detection
  // ---------------------------------------------------------------------------
  logic       hs_q, vs_q, hs_prev_q, vs_prev_q;
  logic [2:0] rgb_q;
  logic       hs_fall, vs_fall;

  // Syncs reset to their idle (high) level so reset itself does not look like an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hsync;
      vs_q      <= vsync;
      hs_prev_q <= hs_q;
      vs_prev_q <= vs_q;
      rgb_q     <= rgb;
    end
  end

  assign hs_fall = hs_prev_q & ~hs_q;
  assign vs_fall = vs_prev_q & ~vs_q;

  // ---------------------------------------------------------------------------
  // Coordinates: x_cur/y_cur belong to the pixel currently held in rgb_q
  // ---------------------------------------------------------------------------
  logic [9:0] x_q, y_q, x_cur, y_cur;

  always_comb begin
    if (hs_fall)              x_cur = '0;
    else if (x_q == CoordMax) x_cur = x_q;
    else                      x_cur = x_q + 10'd1;

    // A vsync edge wins over the hsync edge that normally accompanies it.
    if (vs_fall)                           y_cur = '0;
    else if (hs_fall && y_q != CoordMax)   y_cur = y_q + 10'd1;
    else                                   y_cur = y_q;
  end

  // ---------------------------------------------------------------------------
  // Timing measurement and lock
  // ---------------------------------------------------------------------------
  logic [LineW-1:0]  line_cnt_q, line_cnt_d;
  logic [LineW:0]    line_len;
  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;
  logic              seen_hs_q, seen_vs_q, line_bad_q, locked_q;
  logic              line_err, frame_err, sync_loss, lock_clear, lock_ok;
  logic              line_bad_d, locked_d;

  // line_len = clocks elapsed since the last hsync edge, including this one.
  assign line_len   = {1'b0, line_cnt_q} + (LineW+1)'(1);
  assign line_cnt_d = hs_fall ? '0 :
                      (line_cnt_q == LineMax) ? line_cnt_q : line_cnt_q + LineW'(1);

  // frame_cnt counts hsync edges since the last vsync edge, the vsync line's own
  // edge included; the edge coinciding with a new vsync starts the next frame.
  always_comb begin
    if (vs_fall)                               frame_cnt_d = {{(FrameW-1){1'b0}}, hs_fall};
    else if (hs_fall && frame_cnt_q != FrameMax) frame_cnt_d = frame_cnt_q + FrameW'(1);
    else                                       frame_cnt_d = frame_cnt_q;
  end

  assign line_err   = hs_fall & seen_hs_q & (line_len != (LineW+1)'(H_TOTAL));
  assign frame_err  = vs_fall & seen_vs_q & (frame_cnt_q != FrameW'(V_TOTAL));
  assign sync_loss  = ~hs_fall & (line_len == (LineW+1)'(2 * H_TOTAL));
  assign lock_clear = line_err | frame_err | sync_loss;
  assign lock_ok    = vs_fall & seen_vs_q & ~line_bad_q & ~lock_clear;

  assign locked_d   = lock_clear ? 1'b0 : (lock_ok ? 1'b1 : locked_q);
  // line_bad tracks the frame in progress; the line closed at a vsync edge
  // belongs to the frame being judged, so it is folded into lock_clear instead.
  assign line_bad_d = vs_fall ? 1'b0 : (line_bad_q | line_err | sync_loss);

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      seen_hs_q   <= 1'b0;
      seen_vs_q   <= 1'b0;
      line_bad_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      x_q         <= x_cur;
      y_q         <= y_cur;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      seen_hs_q   <= seen_hs_q | hs_fall;
      seen_vs_q   <= seen_vs_q | vs_fall;
      line_bad_q  <= line_bad_d;
      locked_q    <= locked_d;
    end
  end

  // ---------------------------------------------------------------------------
  // CPU control decode
  // ---------------------------------------------------------------------------
  logic ctrl_sel, ctrl_arm, ctrl_abort;
  logic unused_wdata;

  assign ctrl_sel     = mem_write & (address == 16'(CTRL_ADDR));
  assign ctrl_abort   = ctrl_sel & write_data[1];
  assign ctrl_arm     = ctrl_sel & write_data[0] & ~write_data[1];
  assign unused_wdata = ^write_data[7:2];

  // ---------------------------------------------------------------------------
  // Capture FSM
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;
  logic   error_q, error_d;
  logic   cap_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    error_d   = error_q;
    cap_start = 1'b0;
    if (ctrl_abort) begin
      state_d = StIdle;
      error_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ctrl_arm) begin
            state_d = StArmed;
            error_d = 1'b0;
          end
        end
        StArmed: begin
          if (vs_fall && locked_q) begin
            state_d   = StCapture;
            cap_start = 1'b1;
          end
        end
        StCapture: begin
          if (lock_clear) begin
            state_d = StIdle;
            error_d = 1'b1;
          end else if (y_cur == 10'(V_DISPLAY)) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (ctrl_arm) begin
            state_d = StArmed;
            error_d = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Cell buffer
  // ---------------------------------------------------------------------------
  logic [2:0]      cell_mem [NumCells];
  logic            cell_hit, buf_we;
  logic [IdxW-1:0] buf_idx;

  assign cell_hit = (x_cur[2:0] == 3'd0) && (y_cur[2:0] == 3'd0) &&
                    (x_cur < 10'(H_DISPLAY)) && (y_cur < 10'(V_DISPLAY));
  // The vsync edge that starts a capture carries pixel (0,0), so cap_start
  // enables the write in that same cycle.
  assign buf_we   = cell_hit & ~ctrl_abort &
                    (((state_q == StCapture) & ~lock_clear) | cap_start);
  assign buf_idx  = IdxW'(y_cur[9:3]) * IdxW'(CELL_COLS) + IdxW'(x_cur[9:3]);

  // Contents survive reset on purpose: a reset mid-capture leaves partial data.
  always_ff @(posedge clk) begin
    if (buf_we) cell_mem[buf_idx] <= rgb_q;
  end

  // ---------------------------------------------------------------------------
  // Outputs and CPU read mux
  // ---------------------------------------------------------------------------
  logic busy;

  assign busy         = (state_q == StArmed) | (state_q == StCapture);
  assign locked       = locked_q;
  assign capture_done = (state_q == StDone);

  always_comb begin
    read_data = 8'h00;
    if (address < 16'(NumCells)) begin
      read_data = {5'b0, cell_mem[address[IdxW-1:0]]};
    end else if (address == 16'(CTRL_ADDR)) begin
      read_data = {4'b0, error_q, capture_done, busy, locked_q};
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture, run on a reduced raster (64x40 total, 40x32 visible,
// 5x4 cells) so several whole frames fit in a short run. The source model
// keeps the same sync shape: hsync low for the first 8 clocks of a line,
// vsync low for the first 2 lines, visible region starting at the sync edge.
`timescale 1ns/1ps
module tb_vga_capture;

  localparam int HT       = 64;
  localparam int VT       = 40;
  localparam int HD       = 40;
  localparam int VD       = 32;
  localparam int CC       = 5;
  localparam int CR       = 4;
  localparam int NC       = CC * CR;
  localparam int CTRL     = NC;
  localparam int HS_LEN   = 8;
  localparam int VS_LINES = 2;
  localparam int FRAME    = HT * VT;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsync, vsync;
  logic [2:0]  rgb;
  logic        mem_write;
  logic [15:0] address;
  logic [7:0]  write_data;
  logic [7:0]  read_data;
  logic        locked, capture_done;

  int tests_run    = 0;
  int tests_failed = 0;

  // Source state (written only by the source process) and knobs (main only).
  int hc = 0, vc = 0, cur_len = HT;
  int stretch_vc = -1;
  bit hold_hi    = 1'b0;
  int pat_mul    = 1, pat_off = 0;

  // Expected buffer contents.
  int exp_buf [NC];

  vga_capture #(
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .H_DISPLAY(HD),
    .V_DISPLAY(VD),
    .CELL_COLS(CC),
    .CELL_ROWS(CR),
    .CTRL_ADDR(CTRL)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .mem_write   (mem_write),
    .address     (address),
    .write_data  (write_data),
    .read_data   (read_data),
    .locked      (locked),
    .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  function automatic int cell_val(int c, int r, int m, int o);
    return (c * m + r + o) % 8;
  endfunction

  // Video source: cell-sample pixels carry the pattern, all others are noise.
  initial begin
    hsync = 1'b1;
    vsync = 1'b1;
    rgb   = 3'd0;
    forever begin
      @(posedge clk);
      #1;
      hsync = (hold_hi || hc >= HS_LEN) ? 1'b1 : 1'b0;
      vsync = (vc >= VS_LINES) ? 1'b1 : 1'b0;
      if (hc < HD && vc < VD && hc % 8 == 0 && vc % 8 == 0)
        rgb = 3'(cell_val(hc / 8, vc / 8, pat_mul, pat_off));
      else
        rgb = 3'($urandom);
      hc++;
      if (hc >= cur_len) begin
        hc      = 0;
        vc      = (vc + 1) % VT;
        cur_len = (vc == stretch_vc) ? HT + 1 : HT;
      end
    end
  end

  task automatic cpu_write(input int a, input logic [7:0] d);
    @(negedge clk);
    address    = 16'(a);
    write_data = d;
    mem_write  = 1'b1;
    @(negedge clk);
    mem_write  = 1'b0;
  endtask

  task automatic cpu_read(input int a, output logic [7:0] d);
    @(negedge clk);
    address = 16'(a);
    #1;
    d = read_data;
  endtask

  task automatic wait_src(input int v, input int h, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (vc == v && hc == h) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_locked(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (locked === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (capture_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic set_pattern(input int m, input int o);
    pat_mul = m;
    pat_off = o;
  endtask

  task automatic check_buffer(input string tag);
    logic [7:0] d;
    for (int i = 0; i < NC; i++) begin
      cpu_read(i, d);
      tests_run++;
      if (d !== 8'(exp_buf[i])) begin
        tests_failed++;
        $display("FAIL %s cell %0d: got %02h expected %02h", tag, i, d, 8'(exp_buf[i]));
      end
    end
  endtask

  task automatic check_status(input string tag, input logic [7:0] want);
    logic [7:0] d;
    cpu_read(CTRL, d);
    tests_run++;
    if (d !== want) begin
      tests_failed++;
      $display("FAIL %s: status got %02h expected %02h", tag, d, want);
    end
  endtask

  task automatic check_wait(input string tag, input bit ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL %s: wait expired, got timeout expected event", tag);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    tests_run++;
    if (locked !== 1'b0 || capture_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got locked=%b done=%b expected 0/0", locked, capture_done);
    end
    check_status("reset_status", 8'h00);
    cpu_read(5000, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_read_5000: got %02h expected 00", d);
    end
    cpu_read(CTRL + 1, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_read_ctrl_plus1: got %02h expected 00", d);
    end
  endtask

  task automatic test_lock();
    bit ok;
    wait_src(1, 5, 2 * FRAME, ok);
    check_wait("lock_first_vsync", ok);
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_too_early: got locked=%b expected 0", locked);
    end
    wait_locked(3 * FRAME, ok);
    check_wait("lock_acquire", ok);
    check_status("lock_status", 8'h01);
  endtask

  task automatic test_capture();
    bit ok;
    set_pattern(1, 0);
    for (int r = 0; r < CR; r++)
      for (int c = 0; c < CC; c++) exp_buf[r * CC + c] = (c + r) % 8;
    wait_src(VT - 2, 0, 2 * FRAME, ok);
    check_wait("cap_wait_blank", ok);
    cpu_write(CTRL, 8'h01);
    check_status("cap_armed", 8'h03);
    wait_src(16, 20, 2 * FRAME, ok);
    check_wait("cap_wait_mid", ok);
    check_status("cap_mid_busy", 8'h03);
    cpu_write(CTRL, 8'h01);  // arm during capture must be ignored
    wait_done(FRAME, ok);
    check_wait("cap_done", ok);
    check_status("cap_done_status", 8'h05);
    check_buffer("cap_buf");
  endtask

  task automatic test_lock_loss();
    bit ok;
    wait_src(VT - 2, 0, 2 * FRAME, ok);
    check_wait("loss_wait_blank", ok);
    cpu_write(CTRL, 8'h01);  // DONE -> ARMED, clears done
    check_status("loss_rearm", 8'h03);
    wait_src(10, 0, 2 * FRAME, ok);
    check_wait("loss_wait_line10", ok);
    check_status("loss_capturing", 8'h03);
    stretch_vc = 12;
    wait_src(14, 0, FRAME, ok);
    check_wait("loss_wait_line14", ok);
    stretch_vc = -1;
    check_status("loss_error", 8'h08);
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL loss_locked: got %b expected 0", locked);
    end
    set_pattern(1 + int'($urandom_range(6)), int'($urandom_range(7)));
    for (int r = 0; r < CR; r++)
      for (int c = 0; c < CC; c++) exp_buf[r * CC + c] = cell_val(c, r, pat_mul, pat_off);
    cpu_write(CTRL, 8'h01);
    check_status("loss_rearm_clears_error", 8'h02);
    wait_src(2, 10, FRAME, ok);
    check_wait("loss_wait_next_frame", ok);
    check_status("loss_no_capture_unlocked", 8'h02);
    wait_done(4 * FRAME, ok);
    check_wait("loss_relock_capture", ok);
    check_status("loss_done_status", 8'h05);
    check_buffer("loss_buf");
  endtask

  task automatic test_sync_loss();
    bit ok;
    wait_src(5, 2, 2 * FRAME, ok);
    check_wait("sync_wait", ok);
    hold_hi = 1'b1;
    repeat (100) @(negedge clk);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL sync_hold_early: got locked=%b expected 1", locked);
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_loss: got locked=%b expected 0", locked);
    end
    cpu_write(CTRL, 8'h01);
    check_status("sync_armed", 8'h02);
    cpu_write(CTRL, 8'h03);  // abort wins over arm
    check_status("sync_abort", 8'h00);
    tests_run++;
    if (capture_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL sync_abort_done: got %b expected 0", capture_done);
    end
    hold_hi = 1'b0;
  endtask

  task automatic test_reset_mid_capture();
    bit         ok;
    logic [7:0] d;
    wait_locked(4 * FRAME, ok);
    check_wait("rst_relock", ok);
    set_pattern(1 + int'($urandom_range(6)), int'($urandom_range(7)));
    wait_src(VT - 2, 0, 2 * FRAME, ok);
    check_wait("rst_wait_blank", ok);
    cpu_write(CTRL, 8'h01);
    wait_src(12, 30, 2 * FRAME, ok);
    check_wait("rst_wait_line12", ok);
    check_status("rst_capturing", 8'h03);
    // Rows at y=0 and y=8 are already written; y=16 and y=24 keep old data.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < CC; c++) exp_buf[r * CC + c] = cell_val(c, r, pat_mul, pat_off);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    address = 16'(CTRL);
    #1;
    tests_run++;
    if (read_data !== 8'h00 || capture_done !== 1'b0 || locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_flags: got status=%02h done=%b locked=%b expected 00/0/0",
               read_data, capture_done, locked);
    end
    check_buffer("rst_buf");
    cpu_write(10, 8'($urandom));
    cpu_read(10, d);
    tests_run++;
    if (d !== 8'(exp_buf[10])) begin
      tests_failed++;
      $display("FAIL rst_cpu_write_ignored: got %02h expected %02h", d, 8'(exp_buf[10]));
    end
    cpu_read(5000, d);
    tests_run++;
    if (d !== 8'h00) begin
      tests_failed++;
      $display("FAIL rst_read_5000: got %02h expected 00", d);
    end
  endtask

  initial begin
    reset      = 1'b1;
    mem_write  = 1'b0;
    address    = 16'd0;
    write_data = 8'd0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_lock();
    test_capture();
    test_lock_loss();
    test_sync_loss();
    test_reset_mid_capture();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
